// File: rtl/mult_operand_sequencer.sv
// Initiator-side controller for the ciphertext multiplier: streams two operands into the
// multiplier load port, then reads the product coefficients back out on a valid/ready stream.
module mult_operand_sequencer #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CIPHERTEXT_WIDTH-1:0] in_data,
    output logic [CIPHERTEXT_WIDTH-1:0] mul_entry,
    output logic [DIMENSION:0]          mul_row,
    output logic                        mul_select,
    output logic                        mul_en,
    output logic                        mul_rst_n,
    input  logic [CIPHERTEXT_WIDTH-1:0] mul_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] out_data,
    output logic [DIMENSION:0]          out_index,
    output logic                        done
);

    // Both streams are valid/ready: a beat transfers on a rising edge where valid and ready
    // are both high; the sender holds data stable while valid is high and ready is low.

    localparam int KW = DIMENSION + 1;
    localparam logic [KW-1:0] K_LOAD_LAST = KW'(DIMENSION);
    localparam logic [KW-1:0] K_OUT_LAST  = KW'(2 * DIMENSION);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD_A, LOAD_B, SETTLE, DRAIN, FLUSH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k;
    logic          in_hs;
    logic          out_hs;
    logic          capture;

    assign in_hs   = in_valid & in_ready;
    assign out_hs  = out_valid & out_ready;
    assign capture = (state == DRAIN) & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        in_ready  = (state == LOAD_A) || (state == LOAD_B);
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD_A;
            LOAD_A:  if (in_hs && k == K_LOAD_LAST) state_nxt = LOAD_B;
            LOAD_B:  if (in_hs && k == K_LOAD_LAST) state_nxt = SETTLE;
            SETTLE:  state_nxt = DRAIN;
            DRAIN:   if (capture && k == K_OUT_LAST) state_nxt = FLUSH;
            FLUSH:   if (out_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clear is registered from the next state so it is low exactly while CLEAR is current.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            mul_entry  <= '0;
            mul_row    <= '0;
            mul_select <= 1'b0;
            mul_en     <= 1'b0;
            mul_rst_n  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            done       <= 1'b0;
        end else begin
            mul_en    <= in_hs;
            mul_rst_n <= (state_nxt != CLEAR);
            done      <= (state == FLUSH) && out_hs;

            if (in_hs) begin
                mul_entry  <= in_data;
                mul_select <= (state == LOAD_B);
                mul_row    <= k;
                k          <= (k == K_LOAD_LAST) ? '0 : k + KW'(1);
            end

            if (state == CLEAR) begin
                k <= '0;
            end

            if (state == SETTLE) begin
                k       <= '0;
                mul_row <= '0;
            end

            // During DRAIN mul_row always equals k, so mul_result is the coefficient at k.
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= mul_result;
                out_index <= k;
                if (k == K_OUT_LAST) begin
                    k <= '0;
                end else begin
                    k       <= k + KW'(1);
                    mul_row <= k + KW'(1);
                end
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Bench for mult_operand_sequencer: accumulating multiplier stand-in, convolution-based
// expected queue, directed cases from the test plan plus randomized operations.
module tb_mult_operand_sequencer;

    localparam int W  = 10;
    localparam int D  = 1;
    localparam int IW = D + 1;
    localparam int NOUT = 2 * D + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  mul_entry;
    logic [IW-1:0] mul_row;
    logic          mul_select;
    logic          mul_en;
    logic          mul_rst_n;
    logic [W-1:0]  mul_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_index;
    logic          done;

    mult_operand_sequencer #(.CIPHERTEXT_WIDTH(W), .DIMENSION(D)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mul_entry(mul_entry), .mul_row(mul_row), .mul_select(mul_select),
        .mul_en(mul_en), .mul_rst_n(mul_rst_n), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .done(done)
    );

    // ---------------- clock / counters ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- multiplier stand-in ----------------
    logic [W-1:0] ma [D+1];
    logic [W-1:0] mb [D+1];

    always @(posedge clk) begin
        if (!mul_rst_n) begin
            for (int i = 0; i <= D; i++) begin
                ma[i] <= '0;
                mb[i] <= '0;
            end
        end else if (mul_en && int'(mul_row) <= D) begin
            if (mul_select) mb[int'(mul_row)] <= mb[int'(mul_row)] + mul_entry;
            else            ma[int'(mul_row)] <= ma[int'(mul_row)] + mul_entry;
        end
    end

    always_comb begin
        mul_result = '0;
        for (int i = 0; i <= D; i++)
            for (int j = 0; j <= D; j++)
                if (i + j == int'(mul_row)) mul_result = mul_result + ma[i] * mb[j];
    end

    // ---------------- scoreboard ----------------
    logic [IW+W-1:0] exp_q[$];
    int done_cnt = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int done_cyc = 0;
    bit or_rand = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            logic [IW+W-1:0] item;
            check("ready_idle", {31'd0, in_ready && !busy}, 0);
            check("ready_drain", {31'd0, in_ready && out_valid}, 0);
            check("row_max", {31'd0, int'(mul_row) > 2 * D}, 0);
            if (done) done_cnt++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    item = exp_q.pop_front();
                    check("out_index", 32'(out_index), 32'(item[IW+W-1:W]));
                    check("out_data", 32'(out_data), 32'(item[W-1:0]));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (or_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [D:0][W-1:0] a, input logic [D:0][W-1:0] b,
                            input bit gaps);
        int s;
        logic [W-1:0] c;
        for (int n = 0; n < NOUT; n++) begin
            s = 0;
            for (int i = 0; i <= D; i++)
                if (n - i >= 0 && n - i <= D) s += int'(a[i]) * int'(b[n - i]);
            exp_q.push_back({IW'(n), W'(s % (1 << W))});
        end
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        first_valid_cyc = -1;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int idx = 0; idx < 2 * (D + 1); idx++) begin
            int n;
            bit hs;
            c = (idx <= D) ? a[idx] : b[idx - D - 1];
            if (gaps) begin
                in_valid = 1'b0;
                if (idx == 1) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_data = c;
            in_valid = 1'b1;
            n = 0;
            hs = 1'b0;
            while (!hs && n < 100) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk); #1;
                n++;
            end
            check("in_timeout", {31'd0, !hs}, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n <= 400) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        check("done_timeout", {31'd0, n > 400}, 0);
        done_cyc = cyc;
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", {31'd0, busy}, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_mul_en", {31'd0, mul_en}, 0);
        check("rst_mul_select", {31'd0, mul_select}, 0);
        check("rst_mul_row", 32'(mul_row), 0);
        check("rst_mul_entry", 32'(mul_entry), 0);
        check("rst_mul_rst_n", {31'd0, mul_rst_n}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_index", 32'(out_index), 0);
        check("rst_done", {31'd0, done}, 0);
    endtask

    // ---------------- main sequence ----------------
    logic [D:0][W-1:0] basic_a, basic_b, ra, rb;

    initial begin
        basic_a = {W'(5), W'(3)};
        basic_b = {W'(7), W'(2)};

        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_clear", {31'd0, mul_rst_n}, 1);

        // basic product with latency
        start_op(basic_a, basic_b, 1'b0);
        wait_done();
        check("latency_first_valid", first_valid_cyc - start_cyc, 2 * D + 6);
        check("latency_done", done_cyc - start_cyc, 4 * D + 7);

        // back-to-back: no residue
        start_op({W'(1), W'(1)}, {W'(1), W'(1)}, 1'b0);
        wait_done();

        // wrap-around
        start_op({W'(0), W'(1000)}, {W'(0), W'(2)}, 1'b0);
        wait_done();

        // output backpressure at first out_valid
        out_ready = 1'b0;
        start_op(basic_a, basic_b, 1'b0);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("bp_timeout", {31'd0, !out_valid}, 0);
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                check("bp_valid", {31'd0, out_valid}, 1);
                check("bp_data", 32'(out_data), 6);
                check("bp_index", 32'(out_index), 0);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done();

        // input gaps with start pulsed during LOAD_A
        start_op(basic_a, basic_b, 1'b1);
        wait_done();

        // reset mid-drain
        start_op(basic_a, basic_b, 1'b0);
        begin
            int n;
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                if (out_valid && out_ready) break;
                n++;
            end
            check("rd_timeout", {31'd0, n >= 100}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rd_clear_low", {31'd0, mul_rst_n}, 0);
        @(posedge clk); #1;
        check("rd_clear_high", {31'd0, mul_rst_n}, 1);
        start_op(basic_a, basic_b, 1'b0);
        wait_done();

        // randomized operations
        or_rand = 1'b1;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i <= D; i++) begin
                ra[i] = W'($urandom_range(0, (1 << W) - 1));
                rb[i] = W'($urandom_range(0, (1 << W) - 1));
            end
            start_op(ra, rb, 1'($urandom_range(0, 1)));
            wait_done();
        end
        or_rand = 1'b0;
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_operand_sequencer.md
# mult_operand_sequencer

Initiator-side controller for the ciphertext multiplier. It accepts two ciphertexts of DIMENSION+1 coefficients each on a valid/ready input stream. It drives the multiplier's load port (entry, row, select, enable, active-low clear), waits for the last accumulate to land, then reads the 2·DIMENSION+1 product coefficients back through the multiplier's row-addressed combinational `result_partial` output. The coefficients leave on a valid/ready output stream. The block sits between the operand buffers and the multiplier, so upstream logic never has to sequence rows or clears itself.

## Interface
- CIPHERTEXT_WIDTH, 10, coefficient width in bits; all arithmetic is mod 2^CIPHERTEXT_WIDTH.
- DIMENSION, 1, ciphertext degree; each operand has DIMENSION+1 coefficients and the product has 2·DIMENSION+1.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin an operation; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- in_valid  input  1  input coefficient valid.
- in_ready  output  1  high only in LOAD_A and LOAD_B.
- in_data  input  CIPHERTEXT_WIDTH  input coefficient. Order: A[0..DIMENSION], then B[0..DIMENSION].
- mul_entry  output  CIPHERTEXT_WIDTH  registered coefficient to the multiplier.
- mul_row  output  DIMENSION+1  registered row index to the multiplier; addresses the load and the readback.
- mul_select  output  1  registered; 0 = operand A, 1 = operand B.
- mul_en  output  1  registered write/accumulate enable.
- mul_rst_n  output  1  registered active-low clear of the multiplier.
- mul_result  input  CIPHERTEXT_WIDTH  multiplier `result_partial`, combinational from mul_row.
- out_valid  output  1  product coefficient valid.
- out_ready  input  1  downstream accept.
- out_data  output  CIPHERTEXT_WIDTH  product coefficient.
- out_index  output  DIMENSION+1  coefficient index of out_data, 0..2·DIMENSION.
- done  output  1  one-cycle pulse after the last coefficient is accepted.

## Operation
- States: IDLE, CLEAR, LOAD_A, LOAD_B, SETTLE, DRAIN, FLUSH.
- IDLE
  - mul_rst_n=1, mul_en=0, in_ready=0.
  - start=1 → CLEAR.
- CLEAR
  - mul_rst_n=0 for exactly one cycle; mul_en=0.
  - Index counter k ← 0; next state LOAD_A.
- LOAD_A
  - On each handshake (in_valid&in_ready), next cycle: mul_en=1, mul_select=0, mul_row=k, mul_entry=in_data; then k increments.
  - Without a handshake, mul_en=0 next cycle.
  - After handshake with k=DIMENSION: k ← 0 and go to LOAD_B.
- LOAD_B
  - Same as LOAD_A with mul_select=1.
  - After handshake with k=DIMENSION: go to SETTLE.
- SETTLE
  - One cycle; the last B accumulate lands at the end of it.
  - mul_en returns to 0 after this cycle; k ← 0; next state DRAIN.
- DRAIN
  - mul_en=0, mul_row=k.
  - When !out_valid | out_ready: out_data ← mul_result, out_index ← k, out_valid ← 1, k ← k+1.
  - After capturing k=2·DIMENSION: go to FLUSH.
- FLUSH
  - Wait for the final out handshake, then pulse done for one cycle and go to IDLE.
- Output stream
  - out_valid drops on handshake when nothing new is loaded in the same cycle.
  - out_data and out_index are held stable while out_valid & !out_ready.
- Other rules
  - start outside IDLE is ignored.
  - in_valid outside LOAD_A/LOAD_B is ignored and not consumed.
  - Each operation begins with CLEAR, so back-to-back operations never see stale accumulators.
- Reset
  - Asynchronous at any point, including mid-load or mid-drain.
  - State=IDLE, k=0, busy=0, in_ready=0, mul_en=0, mul_select=0, mul_row=0, mul_entry=0, mul_rst_n=0, out_valid=0, out_data=0, out_index=0, done=0.
  - mul_rst_n rises to 1 on the first clock after reset deasserts.
  - A partial operation is discarded; the next start re-clears the multiplier.

## Timing
- Latency with start at edge t, in_valid held high, and out_ready held high:
  - CLEAR occupies cycle t+1.
  - Loads occupy cycles t+2 .. t+2·DIMENSION+3.
  - SETTLE occupies t+2·DIMENSION+4.
  - DRAIN begins at t+2·DIMENSION+5.
  - First out_valid appears at t+2·DIMENSION+6.
  - Coefficients stream one per cycle.
  - done is high at t+4·DIMENSION+7.
- Input stalls (in_valid low) stretch LOAD_A/LOAD_B one cycle per stall cycle.
- Output stalls (out_ready low) stretch DRAIN/FLUSH one cycle per stall cycle.
- mul_row never exceeds 2·DIMENSION.

## Test plan
- Basic product, DIMENSION=1, W=10: A=(3,5), B=(2,7) → out (index,data) = (0,6), (1,31), (2,35); done pulses once.
- Wrap-around: A=(1000,0), B=(2,0) → (0,976), (1,0), (2,0).
- Back-to-back: run the basic product, then A=(1,1), B=(1,1) → (0,1), (1,2), (2,1). No residue from the first run.
- Backpressure: hold out_ready=0 for 5 cycles at the first out_valid → out_data=6 and out_index=0 held stable, no coefficient lost; then the full sequence.
- Input gaps and ignored start: in_valid toggled every other cycle, start pulsed during LOAD_A → start ignored, results as in the basic product, in_ready never high outside the load states.
- Reset mid-drain: assert rst after the first out handshake → all outputs at reset values, busy=0, mul_rst_n=0 then 1. A fresh basic product afterwards returns 6, 31, 35.
